// File: rtl/mem_arbiter_if.sv
// Core-side request ports and memory-side req/ack port of mem_arbiter.
// slave is the arbiter view; master is the core-plus-memory view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_we;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_addr, d_wdata, d_we,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_addr, mem_wdata, mem_we,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_addr, d_wdata, d_we,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_we,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; `ARB_RR_EN selects round robin, else data wins ties.
// Grant is combinational in IDLE, rvalid follows mem_ack by one cycle; no grants while BUSY (requesters stall).
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  logic [0:0]  state;
  // Last winner doubles as the owner of the in-flight transaction.
  logic        last_win;
  logic        pick_d;
  logic        if_gnt;
  logic        d_gnt;

  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_we_q;
  logic        if_rvalid_q;
  logic        d_rvalid_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  always_comb begin
    pick_d = bus.d_req;
`ifdef ARB_RR_EN
    if (bus.d_req && bus.if_req) begin
      pick_d = (last_win == PORT_IF);
    end
`endif
    if_gnt = (state == IDLE) && bus.if_req && !pick_d;
    d_gnt  = (state == IDLE) && bus.d_req && pick_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_win    <= PORT_D;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 2'b00;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt || d_gnt) begin
            state     <= BUSY;
            mem_req_q <= 1'b1;
            last_win  <= d_gnt;
            if (d_gnt) begin
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
              mem_we_q    <= bus.d_we;
            end else begin
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= 32'h0;
              mem_we_q    <= 2'b00;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            if (last_win == PORT_D) begin
              d_rvalid_q <= 1'b1;
              if (mem_we_q == 2'b00) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one unified instruction/data memory port between the MIPS core's instruction-fetch path and its load/store path. Sits between `mips` (fetch port driven from `pc`, data port driven from `aluout`/`writedata`/`memwrite`) and the single memory, and serialises one transaction at a time over a req/ack memory handshake. The core stalls on each port until that port's `*_rvalid` pulse.

## Interface
- No parameters; all datapaths fixed at 32 bits.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `if_req` input 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` input 32: fetch byte address.
- `if_gnt` output 1: fetch accepted; combinational, only in IDLE.
- `if_rvalid` output 1: one-cycle pulse, `if_rdata` valid.
- `if_rdata` output 32: registered fetch data.
- `d_req` input 1: data request; held with `d_addr`/`d_wdata`/`d_we` stable until `d_gnt`.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data.
- `d_we` input 2: 00 read, 01 byte write, 10 halfword write, 11 word write.
- `d_gnt` output 1: data accepted; combinational, only in IDLE.
- `d_rvalid` output 1: one-cycle completion pulse (reads and writes).
- `d_rdata` output 32: registered load data; unchanged after write completion.
- `mem_req` output 1: registered memory request.
- `mem_addr` output 32, `mem_wdata` output 32, `mem_we` output 2: registered, stable while `mem_req`=1.
- `mem_ack` input 1: memory completion, sampled at rising edge while `mem_req`=1.
- `mem_rdata` input 32: read data, valid in the `mem_ack` cycle.

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- IDLE, no request: all gnt low, stay IDLE.
- IDLE, request(s) present: select winner (see Configuration), assert its gnt in same cycle; at edge latch winner's addr/wdata/we into `mem_*`, set `mem_req`=1, record owner, go BUSY. Fetch always issues `mem_we`=00.
- BUSY: no gnt asserted; requests ignored; `mem_*` held.
- BUSY with `mem_ack`=1 at edge: `mem_req`→0, owner's rvalid→1 for one cycle, owner's rdata←`mem_rdata` if `mem_we`=00, return IDLE.
- `mem_ack` while `mem_req`=0: ignored.
- Only owner receives rvalid; other port's rdata unchanged.
- Last-winner pointer updated on every grant.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=00, `if_gnt`=`d_gnt`=0, `if_rvalid`=`d_rvalid`=0, `if_rdata`=`d_rdata`=0, last-winner=data (fetch wins first tie).
- Request in cycle 0 (IDLE) → gnt cycle 0, `mem_req` cycle 1; `mem_ack` in cycle k≥1 → rvalid cycle k+1.
- Minimum round trip 2 cycles; rvalid cycle is IDLE, so a new grant can issue in it. Peak throughput: one transaction per 2 cycles.
- Reset mid-BUSY: transaction abandoned, `mem_req`=0 next cycle, no rvalid issued, pointer reset.
- Simultaneous `reset` and `mem_ack`: reset wins.

## Configuration
- `ARB_RR_EN` defined: round robin. On a tie, the port that did not win last is granted; a lone request is granted regardless of pointer.
- `ARB_RR_EN` undefined: fixed priority, data over fetch on every tie. Pointer still updated but unused. Fetch may starve under continuous data requests; accepted.

## Test plan
- Reset then `if_req`=1, `if_addr`=0x00400000, `mem_ack` in first `mem_req` cycle, `mem_rdata`=0x20080005 → `if_gnt` cycle 0, `mem_addr`=0x00400000 with `mem_we`=00 cycle 1, `if_rvalid`=1 and `if_rdata`=0x20080005 cycle 2.
- `d_req`, `d_we`=10, `d_addr`=0x1004, `d_wdata`=0xBEEF with `mem_ack` 3 cycles late → `mem_*` stable for all 4 BUSY cycles, `d_rvalid` one cycle after ack, `d_rdata` unchanged.
- Both requests held continuously, ack each first cycle → with `ARB_RR_EN`: grants alternate fetch, data, fetch, data. Without it: data granted every time, `if_gnt` never asserted.
- `if_req` raised while BUSY on data → no `if_gnt` until the `d_rvalid` cycle, where `if_gnt`=1.
- `reset` asserted in BUSY before `mem_ack`, then `mem_ack`=1 → `mem_req`=0 next cycle; no rvalid on either port.
- `mem_ack`=1 in IDLE with no request → no state change, no rvalid.
